instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Upstream stage of instruction_memory: owns the fetch PC and drives the word address into
//  the combinational instruction ROM. Captures each returned word with its PC into a small
//  in-order prefetch FIFO and hands {pc, instr} to decode over a valid/ready handshake.
//  Supports redirect (branch/jump/trap) with a full flush.
// PARAMETERS
//  RESET_PC    32'h00000000  fetch PC loaded on reset; must be word aligned
//  FIFO_DEPTH  4             prefetch entries; power of two, >= 2
// PORTS
//  clk             in   1   single clock; all state updates on rising edge
//  rst_n           in   1   synchronous active-low reset
//  imem_addr       out  32  byte address to instruction memory (= fetch_pc register)
//  imem_rdata      in   32  instruction word returned combinationally for imem_addr
//  redirect_valid  in   1   redirect request this cycle
//  redirect_pc     in   32  target byte address for redirect
//  out_valid       out  1   FIFO head holds a valid instruction
//  out_ready       in   1   decode accepts head this cycle
//  out_instr       out  32  head instruction; 32'h00000013 (NOP) when out_valid=0
//  out_pc          out  32  PC of head instruction; 32'h0 when out_valid=0
//  fetch_fault     out  1   sticky misaligned-redirect flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): fetch_pc=RESET_PC, FIFO count=0, rd/wr ptr=0, fetch_fault=0;
//   so out_valid=0, out_instr=NOP, out_pc=0, imem_addr=RESET_PC.
//  pop  = out_valid & out_ready. push = ~redirect_valid & ~fault_halt & (~full | pop).
//  push: write {fetch_pc, imem_rdata} at wr_ptr; fetch_pc <= fetch_pc + 4 (mod 2^32,
//   32'hFFFFFFFC wraps to 0). No push -> fetch_pc holds, imem_addr stable.
//  Latency: entry pushed at edge N is visible on out_* after edge N (no bypass of an empty
//   FIFO); first out_valid appears 1 cycle after rst_n deasserts.
//  Full and pop in same cycle: push allowed, count unchanged. Empty: pop impossible.
//  Count width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
//  Redirect has priority over push: FIFO flushed (count=0, ptrs=0), fetch_pc <= target,
//   no push that cycle; out_valid=0 next cycle, target's word pushed the cycle after.
//   A pop coinciding with redirect counts as accepted by decode; all other entries dropped.
//  Order strictly preserved; no entry duplicated or lost under any ready pattern.
//  Reset mid-stream overrides everything, including a concurrent redirect.
// CONFIGURATION
//  IFU_MISALIGN_TRAP_EN undefined: redirect target low bits forced to 0 (pc & ~3),
//   fetch_fault tied 0.
//  IFU_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 flushes FIFO, sets
//   fetch_fault=1, loads fetch_pc=redirect_pc unmodified, and asserts fault_halt (no pushes).
//   Only an aligned redirect clears fetch_fault and resumes fetch; reset also clears it.
// TESTING
//  1 rst_n=0 for 2 cycles -> out_valid=0, out_instr=32'h13, out_pc=0, imem_addr=0.
//  2 release reset, out_ready=1, ROM[i]=i -> out_valid from cycle 1; out_pc 0,4,8,...
//    with out_instr 0,1,2,... one per cycle, no gaps.
//  3 out_ready=0 for 10 cycles -> count saturates at 4, imem_addr holds 32'h10;
//    out_ready=1 -> pcs 0,4,8,C,10 in order, then continuous.
//  4 FIFO holds 3, redirect_pc=32'h100 -> next cycle out_valid=0, imem_addr=32'h100;
//    following cycle out_pc=32'h100, out_instr=ROM[64].
//  5 RESET_PC=32'hFFFFFFF8, out_ready=1 -> out_pc FFFFFFF8, FFFFFFFC, 00000000.
//  6 redirect_pc=32'h102: macro off -> next out_pc=32'h100, fetch_fault=0; macro on ->
//    fetch_fault=1, out_valid stays 0 for 8 cycles; redirect 32'h200 clears it, resumes.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Purpose  : Fetch PC owner with an in-order prefetch FIFO feeding decode.
//            Optional misaligned-redirect trap: IFU_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      NOP     = 32'h0000_0013;

  logic [31:0]      fetch_pc;
  logic [31:0]      pc_mem    [FIFO_DEPTH];
  logic [31:0]      instr_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push;
  logic             fault_halt;
  logic [31:0]      redirect_target;

`ifdef IFU_MISALIGN_TRAP_EN
  logic fault_q;

  assign redirect_target = redirect_pc;
  assign fault_halt      = fault_q;
  assign fetch_fault     = fault_q;

  // Sticky until an aligned redirect; a misaligned one (re)arms it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect_valid) begin
      fault_q <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign fault_halt      = 1'b0;
  assign fetch_fault     = 1'b0;
`endif

  assign full      = (count == DEPTH_C);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = ~redirect_valid & ~fault_halt & (~full | pop);
  assign imem_addr = fetch_pc;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : NOP;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : 32'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// Testbench for instruction_fetch_unit: scoreboard of expected {pc, instr}
// popped by a monitor on every accepted output, plus directed timing checks.
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
  logic        fetch_fault;

  logic [31:0] imem_addr2, imem_rdata2;
  logic        out_valid2;
  logic [31:0] out_instr2, out_pc2;
  logic        fetch_fault2;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          pops     = 0;
  int          p0;
  logic [31:0] exp2 [3];

  always #5 clk = ~clk;

  // ROM model: word i holds value i
  assign imem_rdata  = {2'b00, imem_addr[31:2]};
  assign imem_rdata2 = {2'b00, imem_addr2[31:2]};

  instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fetch_fault(fetch_fault)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(out_valid2), .out_ready(1'b1), .out_instr(out_instr2),
    .out_pc(out_pc2), .fetch_fault(fetch_fault2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = base + 32'(4 * i);
      e.instr = {2'b00, e.pc[31:2]};
      sb.push_back(e);
    end
  endtask

  // Monitor: every handshake must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      pops++;
      if (sb.size() == 0) begin
        chk("sb_unexpected_pop_pc", out_pc, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    exp2[0] = 32'hFFFF_FFF8;
    exp2[1] = 32'hFFFF_FFFC;
    exp2[2] = 32'h0000_0000;
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'h13);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_imem_addr_wrap", imem_addr2, 32'hFFFF_FFF8);

    // Release reset, stream with ready=1
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    push_seq(32'h0, 64);
    @(negedge clk);
    chk("first_cycle_not_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
      if (i < 3) chk("wrap_pc", out_pc2, exp2[i]);
    end
    @(posedge clk); #1;
    chk("stream_pops", pops, 8);
    out_ready = 1'b0;

    // Stall: FIFO fills, fetch PC holds
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("stall_imem_addr", imem_addr, 32'h30);
    chk("stall_head_pc", out_pc, 32'h20);
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    p0 = pops;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("drain_valid", {31'b0, out_valid}, 32'd1);
      @(posedge clk);
    end
    #1;
    chk("drain_pops", pops - p0, 6);

    // Redirect to 0x40, let three entries accumulate
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    sb.delete();
    push_seq(32'h40, 1);
    @(negedge clk);
    chk("redir_valid0", {31'b0, out_valid}, 32'd0);
    chk("redir_imem_addr", imem_addr, 32'h40);
    chk("redir_nop", out_instr, 32'h13);
    chk("redir_pc0", out_pc, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    // Redirect with 3 held entries and a coincident pop of the head
    redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
    @(negedge clk);
    chk("hold3_head", out_pc, 32'h40);
    chk("hold3_imem_addr", imem_addr, 32'h4C);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    sb.delete();
    push_seq(32'h100, 32);
    @(negedge clk);
    chk("flush_valid0", {31'b0, out_valid}, 32'd0);
    chk("flush_imem_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk("target_pc", out_pc, 32'h100);
    chk("target_instr", out_instr, 32'h40);
    repeat (4) @(posedge clk);
    #1;

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    sb.delete();
`ifndef IFU_MISALIGN_TRAP_EN
    push_seq(32'h100, 16);
    @(negedge clk);
    chk("mis_valid0", {31'b0, out_valid}, 32'd0);
    chk("mis_fault", {31'b0, fetch_fault}, 32'd0);
    chk("mis_imem_addr", imem_addr, 32'h100);
    @(negedge clk);
    chk("mis_pc", out_pc, 32'h100);
`else
    @(negedge clk);
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    chk("mis_imem_addr", imem_addr, 32'h102);
    repeat (8) begin
      @(negedge clk);
      chk("mis_halt_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    push_seq(32'h200, 16);
    @(negedge clk);
    chk("clr_fault", {31'b0, fetch_fault}, 32'd0);
    chk("clr_valid0", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("resume_pc", out_pc, 32'h200);
`endif
    repeat (2) @(posedge clk);
    #1;

    // Reset overrides a concurrent redirect
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(posedge clk); #1;
    rst_n = 1'b1; redirect_valid = 1'b0;
    sb.delete();
    push_seq(32'h0, 8);
    @(negedge clk);
    chk("mid_rst_imem_addr", imem_addr, 32'h0);
    chk("mid_rst_valid0", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("mid_rst_first_pc", out_pc, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
